// File: rtl/morse_pkg.sv
// morse_pkg: types and constants shared by the Morse element classifier and
// the downstream letter-lookup stage.
//   morse_state_t : classifier FSM states
//   DOT / DASH    : element encoding in the letter buffer
//   MAX_ELEMS     : element slots per letter
//   DUR_W/DUR_MAX : duration counter width and saturation value
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } morse_state_t;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int MAX_ELEMS = 5;
  localparam int DUR_W     = 3;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

endpackage

// File: rtl/morse_dur_counter.sv
// morse_dur_counter: saturating tick counter measuring press/release duration.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, has priority over inc
//   inc   : count one tick
//   cnt   : current duration in ticks, sticks at DUR_MAX
module morse_dur_counter
  import morse_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [DUR_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != DUR_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_element_classifier.sv
// morse_element_classifier: classifies key presses (measured in counter-wrap
// ticks) as dot/dash, collects them into a letter and strobes the letter out
// once the key has stayed released for LETTER_GAP_TICKS.
// Optional feature macro: MORSE_WORD_GAP_EN adds the word_gap port and keeps
// counting released ticks in IDLE after a letter to flag a word gap.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   tick      : one-cycle pulse per counter wrap
//   key       : synchronized key level, 1 = pressed
//   sym_valid : one-cycle strobe, letter outputs valid
//   sym_bits  : element bits, first element in bit 0, 1 = dash
//   sym_len   : element count of the letter (1..5)
//   sym_ovf   : letter had more than 5 elements, extras dropped
//   word_gap  : one-cycle word gap strobe (MORSE_WORD_GAP_EN only)
//
// state | meaning
// IDLE  | no elements pending (counts toward word gap when enabled)
// PRESS | key held, measuring element duration
// GAP   | key released with a letter open, measuring gap
module morse_element_classifier
  import morse_pkg::*;
#(
  parameter int DASH_TICKS       = 3,
  parameter int LETTER_GAP_TICKS = 3,
  parameter int WORD_GAP_TICKS   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 key,
  output logic                 sym_valid,
  output logic [MAX_ELEMS-1:0] sym_bits,
  output logic [2:0]           sym_len,
  output logic                 sym_ovf
`ifdef MORSE_WORD_GAP_EN
  ,
  output logic                 word_gap
`endif
);

  morse_state_t state, state_nxt;

  logic [DUR_W-1:0]     cnt;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 push;
  logic                 emit;
  logic                 elem;
  logic [MAX_ELEMS-1:0] elem_buf;
  logic [2:0]           elem_len;
  logic                 elem_ovf;

`ifdef MORSE_WORD_GAP_EN
  logic wg_armed;
  logic wg_pulse;
`endif

  morse_dur_counter u_dur (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  assign elem = (cnt >= DUR_W'(DASH_TICKS)) ? DASH : DOT;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = tick;
    push      = 1'b0;
    emit      = 1'b0;
`ifdef MORSE_WORD_GAP_EN
    wg_pulse  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef MORSE_WORD_GAP_EN
        cnt_inc = tick && wg_armed;
`else
        cnt_inc = 1'b0;
`endif
        if (key) begin
          state_nxt = PRESS;
          cnt_clr   = 1'b1;
        end
`ifdef MORSE_WORD_GAP_EN
        else if (wg_armed && tick && (cnt == DUR_W'(WORD_GAP_TICKS - 1))) begin
          wg_pulse = 1'b1;
        end
`endif
      end
      PRESS: begin
        if (!key) begin
          state_nxt = GAP;
          cnt_clr   = 1'b1;
          push      = 1'b1;
        end
      end
      GAP: begin
        if (key) begin
          state_nxt = PRESS;
          cnt_clr   = 1'b1;
        end else if (tick && (cnt == DUR_W'(LETTER_GAP_TICKS - 1))) begin
          state_nxt = IDLE;
          emit      = 1'b1;
`ifndef MORSE_WORD_GAP_EN
          cnt_clr   = 1'b1;
`endif
          // with word gap enabled the count runs on through IDLE so the
          // letter-gap ticks count toward the word gap
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_buf  <= '0;
      elem_len  <= '0;
      elem_ovf  <= 1'b0;
      sym_valid <= 1'b0;
      sym_bits  <= '0;
      sym_len   <= '0;
      sym_ovf   <= 1'b0;
    end else begin
      sym_valid <= emit;
      if (push) begin
        if (elem_len < 3'(MAX_ELEMS)) begin
          elem_buf <= elem_buf | (MAX_ELEMS'(elem) << elem_len);
          elem_len <= elem_len + 1'b1;
        end else begin
          elem_ovf <= 1'b1;
        end
      end else if (emit) begin
        sym_bits <= elem_buf;
        sym_len  <= elem_len;
        sym_ovf  <= elem_ovf;
        elem_buf <= '0;
        elem_len <= '0;
        elem_ovf <= 1'b0;
      end
    end
  end

`ifdef MORSE_WORD_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wg_armed <= 1'b0;
      word_gap <= 1'b0;
    end else begin
      word_gap <= wg_pulse;
      if (key || wg_pulse) begin
        wg_armed <= 1'b0;
      end else if (emit) begin
        wg_armed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_morse_element_classifier.sv
// tb_morse_element_classifier: directed stimulus for the Morse classifier with
// hand-computed expected letters. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_morse_element_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       key = 1'b0;
  logic       sym_valid;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       sym_ovf;
`ifdef MORSE_WORD_GAP_EN
  logic       word_gap;
  int         wcnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int vbase;
  logic [4:0] cap_bits = '0;
  logic [2:0] cap_len  = '0;
  logic       cap_ovf  = 1'b0;

  morse_element_classifier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .key       (key),
    .sym_valid (sym_valid),
    .sym_bits  (sym_bits),
    .sym_len   (sym_len),
    .sym_ovf   (sym_ovf)
`ifdef MORSE_WORD_GAP_EN
    ,
    .word_gap  (word_gap)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sym_valid) begin
      vcnt     <= vcnt + 1;
      cap_bits <= sym_bits;
      cap_len  <= sym_len;
      cap_ovf  <= sym_ovf;
    end
`ifdef MORSE_WORD_GAP_EN
    if (word_gap) wcnt <= wcnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  // hold key for n ticks then release
  task automatic press(input int n);
    @(negedge clk) key = 1'b1;
    do_tick(n);
    @(negedge clk) key = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_letter(input string tag, input int vexp, input logic [4:0] b,
                            input logic [2:0] l, input logic o);
    settle();
    chk({tag, "_count"}, vcnt, vexp);
    chk({tag, "_bits"}, cap_bits, b);
    chk({tag, "_len"}, cap_len, l);
    chk({tag, "_ovf"}, cap_ovf, o);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", sym_valid, 0);
    chk("rst_bits", sym_bits, 0);
    chk("rst_len", sym_len, 0);
    chk("rst_ovf", sym_ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    settle();

    // "E": single 1-tick dot
    press(1);
    do_tick(2);
    settle();
    chk("e_early", vcnt, 0);
    do_tick(1);
    chk_letter("e", 1, 5'b00000, 3'd1, 1'b0);

    // "C": dash dot dash dot
    press(4); do_tick(1);
    press(1); do_tick(1);
    press(4); do_tick(1);
    press(1); do_tick(3);
    chk_letter("c", 2, 5'b00101, 3'd4, 1'b0);

    // dash threshold boundary: 2 ticks -> dot, 3 ticks -> dash, no tick -> dot
    press(2); do_tick(1);
    press(3); do_tick(1);
    press(0); do_tick(1);
    press(7); do_tick(3);
    chk_letter("thr", 3, 5'b01010, 3'd4, 1'b0);

    // six dots: overflow, extra dropped
    for (int i = 0; i < 6; i++) begin
      press(1);
      do_tick(i == 5 ? 3 : 1);
    end
    chk_letter("ovf", 4, 5'b00000, 3'd5, 1'b1);
    press(4); do_tick(3);
    chk_letter("ovf_next", 5, 5'b00001, 3'd1, 1'b0);

    // key rise coincides with the tick that would close the letter
    press(1);
    do_tick(2);
    @(negedge clk) begin key = 1'b1; tick = 1'b1; end
    @(negedge clk) tick = 1'b0;
    settle();
    chk("sim_noemit", vcnt, 5);
    do_tick(4);
    @(negedge clk) key = 1'b0;
    do_tick(3);
    chk_letter("sim", 6, 5'b00010, 3'd2, 1'b0);

    // reset mid-press with two elements buffered
    press(1); do_tick(1);
    press(4); do_tick(1);
    @(negedge clk) key = 1'b1;
    do_tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_len", sym_len, 0);
    chk("arst_bits", sym_bits, 0);
    @(negedge clk) key = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    vbase = vcnt;
    do_tick(5);
    settle();
    chk("arst_noemit", vcnt, vbase);
    press(1); do_tick(3);
    chk_letter("post_rst", vbase + 1, 5'b00000, 3'd1, 1'b0);

`ifdef MORSE_WORD_GAP_EN
    vbase = vcnt;
    press(4);
    do_tick(3);
    settle();
    chk("wg_letter", vcnt, vbase + 1);
    chk("wg_none_at3", wcnt, 0);
    do_tick(3);
    settle();
    chk("wg_none_at6", wcnt, 0);
    do_tick(1);
    settle();
    chk("wg_at7", wcnt, 1);
    do_tick(5);
    settle();
    chk("wg_once", wcnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_element_classifier.md
# morse_element_classifier

Downstream consumer of the mod-25 tick counter: turns the debounced key line into Morse elements and whole letters. Press duration is measured in counter-wrap ticks and classified as dot or dash. Elements accumulate into a letter buffer. A letter is emitted as a one-cycle strobe once the key has stayed released for the letter-gap time. The letter-lookup stage consumes this output.

## Interface
- DASH_TICKS, 3, minimum press length in ticks to classify as dash; legal range 1..7
- LETTER_GAP_TICKS, 3, released ticks that close a letter; legal range 1..7
- WORD_GAP_TICKS, 7, released ticks that flag a word gap; must be > LETTER_GAP_TICKS and ≤ 7
- CLK  input  1  system clock; all state updates on rising edge
- RST_N  input  1  reset, asynchronous assert, active-low
- TICK  input  1  one-CLK pulse when the mod-25 counter wraps 24→0
- KEY  input  1  synchronized key level, 1 = pressed
- SYM_VALID  output  1  one-cycle strobe; letter outputs valid
- SYM_BITS  output  5  element bits, first element in bit 0; 0 = dot, 1 = dash; unused bits 0
- SYM_LEN  output  3  element count, 1..5
- SYM_OVF  output  1  letter held more than 5 elements; extras dropped
- WORD_GAP  output  1  one-cycle strobe on word gap; present only with MORSE_WORD_GAP_EN

## Operation
- Reset (RST_N=0):
  - State = IDLE.
  - Duration counter, buffer, length and overflow = 0.
  - All outputs = 0.
- Duration counter: 3 bits, saturates at 7, increments only on TICK. It clears on every state transition.
- IDLE (no elements pending):
  - KEY=1 → PRESS.
- PRESS (key held):
  - KEY=0 → classify the element. Count ≥ DASH_TICKS → dash, else dot. A press released before any tick is a dot.
  - If length < 5: write the element at bit[length] and increment length. Otherwise set overflow and drop the element.
  - Next state → GAP.
- GAP (key released, letter open):
  - KEY=1 → PRESS. The element joins the same letter.
  - On the TICK where count becomes LETTER_GAP_TICKS: load SYM_BITS, SYM_LEN and SYM_OVF, and pulse SYM_VALID.
  - Then clear buffer, length and overflow, and go → IDLE.
- Simultaneous KEY change and TICK in one cycle: the KEY transition wins, the tick is discarded and the counter clears.
- SYM_BITS, SYM_LEN and SYM_OVF hold their last letter until the next SYM_VALID.
- Reset mid-letter discards the partial letter; nothing is emitted.

## Timing
- All outputs are registered.
- SYM_VALID is high for exactly the one cycle after the CLK edge that samples the closing TICK.
- Element classification takes effect on the CLK edge that samples KEY=0. Latency is 1 cycle from the KEY fall to the buffer update.
- Letter latency: LETTER_GAP_TICKS ticks after release, plus 1 CLK.
- No back-pressure. The consumer must accept SYM_VALID in the cycle it is asserted.

## Configuration
- Macro MORSE_WORD_GAP_EN.
- Defined:
  - WORD_GAP port exists.
  - After a letter is emitted, IDLE keeps counting ticks. Counting continues from the release, so the letter-gap ticks are included.
  - WORD_GAP pulses one cycle when the count reaches WORD_GAP_TICKS. It pulses at most once per idle period and re-arms on the next KEY=1.
  - A press before WORD_GAP_TICKS cancels the pulse.
- Undefined:
  - No WORD_GAP port.
  - IDLE does not count.
  - Behaviour is otherwise identical.

## Structure
- Package morse_pkg:
  - State enum (IDLE, PRESS, GAP).
  - DOT=1'b0 and DASH=1'b1.
  - MAX_ELEMS=5 and the duration width of 3.
  - Shared by the letter-lookup stage.
- Sub-module morse_dur_counter: 3-bit saturating tick counter with synchronous clear and asynchronous active-low reset. It is instantiated once.
- Top level holds the FSM, the element buffer and the output registers.

## Test plan
- Press 1 tick, release, wait 3 ticks → SYM_VALID once; SYM_BITS=5'b00000, SYM_LEN=1, SYM_OVF=0 ("E").
- Press 4 ticks, gap 1, press 1, gap 1, press 4, gap 1, press 1, release, wait 3 ticks → SYM_BITS=5'b00101, SYM_LEN=4 ("C").
- Six 1-tick presses separated by 1-tick gaps → SYM_LEN=5, SYM_OVF=1, SYM_BITS=0; the next letter has SYM_OVF=0.
- KEY rises in the same cycle as TICK during GAP at count 2 → no letter emitted; the element joins the current letter.
- RST_N pulled low mid-PRESS with 2 elements buffered → outputs 0 asynchronously; no SYM_VALID after release.
- With MORSE_WORD_GAP_EN, release then idle 7 ticks → SYM_VALID at tick 3, WORD_GAP at tick 7, no second WORD_GAP at later ticks.
